bp_lite_to_stream: RTL and testbench

- Serializes one BP Lite memory message (header plus a full-width data block) into a BP Stream of narrow beats.
- Each beat carries a copy of the header with an advancing address, plus one narrow data slice.
- It is the mirror stage of the stream-to-lite converter and sits between a wide Lite producer (CCE/cache engine or memory model) and a narrow stream consumer (network link or DRAM adapter).
- Holds exactly one message at a time.
- A `mem_lock_o` signal keeps downstream arbiters on this stream until the last beat.

---
 rtl/bp_lite_to_stream.sv | 147 ++++++++++++++
 tb/tb_bp_lite_to_stream.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_lite_to_stream.sv
// bp_lite_to_stream
// Splits one wide Lite memory message into a burst of narrow stream beats.
// Each beat repeats the header with an address that advances in
// critical-word-first order, wrapping inside the 2^size aligned region.
// Only one message is held at a time. The final beat can overlap with the
// accept of the next message, so back-to-back messages leave no bubble.
//
// Header layout, MSB to LSB:
//   {msg_type[3:0], addr[paddr_width_p-1:0], size[2:0], payload[payload_width_p-1:0]}
// The message on mem_i is {data[in_data_width_p-1:0], header}.
//
// Ports:
//   clk_i, reset_i  clock and asynchronous active-high reset
//   mem_i           Lite message (header plus wide data)
//   mem_v_i         Lite message valid
//   mem_ready_o     Lite ready; combinational in mem_ready_i only
//   mem_header_o    per-beat header with the advanced address
//   mem_data_o      per-beat data slice
//   mem_v_o         stream beat valid
//   mem_ready_i     stream ready
//   mem_lock_o      high on every beat except the last beat of a message
module bp_lite_to_stream #(
    parameter int unsigned paddr_width_p    = 40,
    parameter int unsigned payload_width_p  = 16,
    parameter int unsigned in_data_width_p  = 512,
    parameter int unsigned out_data_width_p = 64,
    parameter bit          master_p         = 1'b0,
    localparam int unsigned TYPE_W = 4,
    localparam int unsigned SIZE_W = 3,
    localparam int unsigned HDR_W  = TYPE_W + paddr_width_p + SIZE_W + payload_width_p,
    localparam int unsigned MSG_W  = HDR_W + in_data_width_p
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [MSG_W-1:0]            mem_i,
    input  logic                        mem_v_i,
    output logic                        mem_ready_o,
    output logic [HDR_W-1:0]            mem_header_o,
    output logic [out_data_width_p-1:0] mem_data_o,
    output logic                        mem_v_o,
    input  logic                        mem_ready_i,
    output logic                        mem_lock_o
);

    localparam int unsigned NBEAT = in_data_width_p / out_data_width_p;
    localparam int unsigned CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int unsigned K     = $clog2(out_data_width_p / 8);
    localparam int unsigned SIZE_LSB = payload_width_p;
    localparam int unsigned ADDR_LSB = payload_width_p + SIZE_W;
    localparam int unsigned TYPE_LSB = ADDR_LSB + paddr_width_p;

    localparam logic [TYPE_W-1:0] MSG_WR    = 4'd1;
    localparam logic [TYPE_W-1:0] MSG_UC_WR = 4'd3;

    logic                        r_v;
    logic [CW-1:0]               r_cnt;
    logic [CW-1:0]               r_last;
    logic [HDR_W-1:0]            r_hdr;
    logic [in_data_width_p-1:0]  r_data;

    logic [TYPE_W-1:0]           w_in_type;
    logic [SIZE_W-1:0]           w_in_size;
    logic                        w_in_is_wr;
    logic                        w_in_carries;
    logic [CW-1:0]               w_in_last;
    logic                        w_accept;
    logic                        w_beat_fire;
    logic                        w_is_last;
    logic [paddr_width_p-1:0]    w_addr;
    logic [SIZE_W-1:0]           w_size;
    logic [paddr_width_p-1:0]    w_mask;
    logic [paddr_width_p-1:0]    w_offset;
    logic [paddr_width_p-1:0]    w_addr_o;
    logic [NBEAT-1:0][out_data_width_p-1:0] w_words;

    // Incoming header decode: does this message carry data, and how many beats
    assign w_in_type    = mem_i[TYPE_LSB +: TYPE_W];
    assign w_in_size    = mem_i[SIZE_LSB +: SIZE_W];
    assign w_in_is_wr   = (w_in_type == MSG_WR) || (w_in_type == MSG_UC_WR);
    assign w_in_carries = master_p ? w_in_is_wr : ~w_in_is_wr;

    always_comb begin
        w_in_last = '0;
        if (w_in_carries && (32'(w_in_size) > K)) begin
            w_in_last = CW'((32'd1 << (32'(w_in_size) - K)) - 32'd1);
        end
    end

    // Handshakes
    assign w_is_last   = (r_cnt == r_last);
    assign w_beat_fire = r_v & mem_ready_i;
    assign mem_ready_o = ~reset_i & (~r_v | (w_is_last & mem_ready_i));
    assign w_accept    = mem_v_i & mem_ready_o;

    // Control state: valid flag, beat counter, last-beat index
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v    <= 1'b0;
            r_cnt  <= '0;
            r_last <= '0;
        end else if (w_accept) begin
            r_v    <= 1'b1;
            r_cnt  <= '0;
            r_last <= w_in_last;
        end else if (w_beat_fire) begin
            if (w_is_last) begin
                r_v   <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Message holding register; contents are only meaningful while r_v is set
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_hdr  <= mem_i[HDR_W-1:0];
            r_data <= mem_i[HDR_W +: in_data_width_p];
        end
    end

    // Address advances by one beat's bytes and wraps inside the 2^size block
    assign w_addr   = r_hdr[ADDR_LSB +: paddr_width_p];
    assign w_size   = r_hdr[SIZE_LSB +: SIZE_W];
    assign w_mask   = (paddr_width_p'(1) << w_size) - paddr_width_p'(1);
    assign w_offset = paddr_width_p'(r_cnt) << K;
    assign w_addr_o = (32'(w_size) > K)
                    ? ((w_addr & ~w_mask) | ((w_addr + w_offset) & w_mask))
                    : w_addr;

    // Stream outputs
    assign w_words      = r_data;
    assign mem_data_o   = w_words[r_cnt];
    assign mem_header_o = {r_hdr[TYPE_LSB +: TYPE_W], w_addr_o, r_hdr[ADDR_LSB-1:0]};
    assign mem_v_o      = r_v;
    assign mem_lock_o   = r_v & (r_cnt != r_last);

    // Illegal configuration or message size
    always_ff @(posedge clk_i) begin
        assert (in_data_width_p % out_data_width_p == 0);
        if (!reset_i && w_accept) begin
            assert ((32'd1 << w_in_size) <= (in_data_width_p / 8));
        end
    end

endmodule

// File: tb/tb_bp_lite_to_stream.sv
// Directed bench for bp_lite_to_stream: one response-direction instance
// (master_p=0) and one command-direction instance (master_p=1).
module tb_bp_lite_to_stream;

    localparam int unsigned PA    = 40;
    localparam int unsigned PL    = 16;
    localparam int unsigned IN_W  = 512;
    localparam int unsigned OUT_W = 64;
    localparam int unsigned HDR_W = 4 + PA + 3 + PL;
    localparam int unsigned MSG_W = HDR_W + IN_W;

    localparam logic [3:0] RD = 4'd0;
    localparam logic [3:0] WR = 4'd1;

    logic clk = 1'b0;
    logic rst;
    logic [MSG_W-1:0] mem_i;

    logic v0, rdy0, ready0, vo0, lock0;
    logic [HDR_W-1:0] hdr0;
    logic [OUT_W-1:0] data0;

    logic v1, rdy1, ready1, vo1, lock1;
    logic [HDR_W-1:0] hdr1;
    logic [OUT_W-1:0] data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_lite_to_stream #(
        .paddr_width_p(PA), .payload_width_p(PL),
        .in_data_width_p(IN_W), .out_data_width_p(OUT_W), .master_p(1'b0)
    ) u_rsp (
        .clk_i(clk), .reset_i(rst), .mem_i(mem_i), .mem_v_i(v0),
        .mem_ready_o(ready0), .mem_header_o(hdr0), .mem_data_o(data0),
        .mem_v_o(vo0), .mem_ready_i(rdy0), .mem_lock_o(lock0)
    );

    bp_lite_to_stream #(
        .paddr_width_p(PA), .payload_width_p(PL),
        .in_data_width_p(IN_W), .out_data_width_p(OUT_W), .master_p(1'b1)
    ) u_cmd (
        .clk_i(clk), .reset_i(rst), .mem_i(mem_i), .mem_v_i(v1),
        .mem_ready_o(ready1), .mem_header_o(hdr1), .mem_data_o(data1),
        .mem_v_o(vo1), .mem_ready_i(rdy1), .mem_lock_o(lock1)
    );

    function automatic logic [HDR_W-1:0] mk_hdr(input logic [3:0] t, input logic [PA-1:0] a,
                                                  input logic [2:0] s, input logic [PL-1:0] p);
        return {t, a, s, p};
    endfunction

    function automatic logic [IN_W-1:0] mk_data(input logic [7:0] seed);
        logic [IN_W-1:0] d;
        for (int j = 0; j < 64; j++) d[j*8 +: 8] = 8'(seed + 8'(j));
        return d;
    endfunction

    function automatic logic [OUT_W-1:0] slice(input logic [IN_W-1:0] d, input int i);
        return d[i*OUT_W +: OUT_W];
    endfunction

    // 64-byte wrap with 8-byte beats
    function automatic logic [PA-1:0] wrap_addr(input logic [PA-1:0] a, input int i);
        return {a[PA-1:6], 6'(a[5:0] + 6'(8 * i))};
    endfunction

    task automatic test_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1; mem_i = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL reset_v got %b exp 0", vo0); end
        checks++; if (lock0 !== 1'b0) begin errors++; $display("FAIL reset_lock got %b exp 0", lock0); end
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b exp 0", ready0); end
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b exp 0", ready1); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL post_reset_ready0 got %b exp 1", ready0); end
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL post_reset_ready1 got %b exp 1", ready1); end
        checks++; if (vo1 !== 1'b0) begin errors++; $display("FAIL post_reset_v1 got %b exp 0", vo1); end
    endtask

    task automatic test_wide_read();
        logic [IN_W-1:0]  d = mk_data(8'h00);
        logic [PA-1:0]    a = 40'h00_8000_0010;
        logic [HDR_W-1:0] eh;
        @(negedge clk);
        mem_i = {d, mk_hdr(RD, a, 3'd6, 16'h1234)}; v0 = 1'b1; rdy0 = 1'b1;
        #1;
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL wide_idle_ready got %b exp 1", ready0); end
        checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL wide_no_comb_v got %b exp 0", vo0); end
        @(negedge clk);
        v0 = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            eh = mk_hdr(RD, wrap_addr(a, i), 3'd6, 16'h1234);
            checks++; if (vo0 !== 1'b1) begin errors++; $display("FAIL wide_v beat %0d got %b exp 1", i, vo0); end
            checks++; if (hdr0 !== eh) begin errors++; $display("FAIL wide_hdr beat %0d got %h exp %h", i, hdr0, eh); end
            checks++; if (data0 !== slice(d, i)) begin errors++; $display("FAIL wide_data beat %0d got %h exp %h", i, data0, slice(d, i)); end
            checks++; if (lock0 !== (i != 7)) begin errors++; $display("FAIL wide_lock beat %0d got %b exp %b", i, lock0, (i != 7)); end
            @(negedge clk);
            #1;
        end
        checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL wide_end_v got %b exp 0", vo0); end
    endtask

    task automatic test_single(input string nm, input logic [3:0] t, input logic [PA-1:0] a,
                               input logic [2:0] s, input logic [7:0] seed);
        logic [IN_W-1:0]  d = mk_data(seed);
        logic [HDR_W-1:0] h = mk_hdr(t, a, s, 16'h0055);
        @(negedge clk);
        mem_i = {d, h}; v0 = 1'b1; rdy0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        #1;
        checks++; if (vo0 !== 1'b1) begin errors++; $display("FAIL %s_v got %b exp 1", nm, vo0); end
        checks++; if (hdr0 !== h) begin errors++; $display("FAIL %s_hdr got %h exp %h", nm, hdr0, h); end
        checks++; if (data0 !== slice(d, 0)) begin errors++; $display("FAIL %s_data got %h exp %h", nm, data0, slice(d, 0)); end
        checks++; if (lock0 !== 1'b0) begin errors++; $display("FAIL %s_lock got %b exp 0", nm, lock0); end
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL %s_ready got %b exp 1", nm, ready0); end
        @(negedge clk);
        #1;
        checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL %s_end_v got %b exp 0", nm, vo0); end
    endtask

    task automatic test_small_read();
        test_single("small_rd", RD, 40'h00_0000_1004, 3'd2, 8'h40);
    endtask

    task automatic test_write_ack();
        test_single("wr_ack", WR, 40'h00_0000_2000, 3'd6, 8'hC0);
    endtask

    task automatic test_write_cmd();
        logic [IN_W-1:0]  d = mk_data(8'h20);
        logic [PA-1:0]    a = 40'h00_0000_2038;
        logic [HDR_W-1:0] eh;
        @(negedge clk);
        mem_i = {d, mk_hdr(WR, a, 3'd6, 16'h0777)}; v1 = 1'b1; rdy1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            eh = mk_hdr(WR, wrap_addr(a, i), 3'd6, 16'h0777);
            checks++; if (vo1 !== 1'b1) begin errors++; $display("FAIL cmd_v beat %0d got %b exp 1", i, vo1); end
            checks++; if (hdr1 !== eh) begin errors++; $display("FAIL cmd_hdr beat %0d got %h exp %h", i, hdr1, eh); end
            checks++; if (data1 !== slice(d, i)) begin errors++; $display("FAIL cmd_data beat %0d got %h exp %h", i, data1, slice(d, i)); end
            checks++; if (lock1 !== (i != 7)) begin errors++; $display("FAIL cmd_lock beat %0d got %b exp %b", i, lock1, (i != 7)); end
            @(negedge clk);
            #1;
        end
        checks++; if (vo1 !== 1'b0) begin errors++; $display("FAIL cmd_end_v got %b exp 0", vo1); end
    endtask

    task automatic test_backpressure();
        logic [IN_W-1:0]  d = mk_data(8'h80);
        logic [PA-1:0]    a = 40'h00_8000_0010;
        logic [HDR_W-1:0] eh;
        int beats = 0;
        @(negedge clk);
        mem_i = {d, mk_hdr(RD, a, 3'd6, 16'h0BEE)}; v0 = 1'b1; rdy0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
            rdy0 = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            #1;
            eh = mk_hdr(RD, wrap_addr(a, beats), 3'd6, 16'h0BEE);
            checks++; if (vo0 !== 1'b1) begin errors++; $display("FAIL bp_v cyc %0d got %b exp 1", cyc, vo0); end
            checks++; if (hdr0 !== eh) begin errors++; $display("FAIL bp_hdr cyc %0d got %h exp %h", cyc, hdr0, eh); end
            checks++; if (data0 !== slice(d, beats)) begin errors++; $display("FAIL bp_data cyc %0d got %h exp %h", cyc, data0, slice(d, beats)); end
            checks++; if (ready0 !== (beats == 7 && rdy0)) begin errors++; $display("FAIL bp_ready cyc %0d got %b exp %b", cyc, ready0, (beats == 7 && rdy0)); end
            if (rdy0) beats++;
            @(negedge clk);
        end
        rdy0 = 1'b1;
        #1;
        checks++; if (beats !== 8) begin errors++; $display("FAIL bp_beat_count got %0d exp 8", beats); end
        checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL bp_end_v got %b exp 0", vo0); end
    endtask

    task automatic test_back_to_back();
        logic [IN_W-1:0]  da = mk_data(8'h10);
        logic [IN_W-1:0]  db = mk_data(8'h90);
        logic [PA-1:0]    aa = 40'h00_0000_0100;
        logic [PA-1:0]    ab = 40'h00_0000_0240;
        logic [HDR_W-1:0] eh;
        logic [OUT_W-1:0] ed;
        int i;
        @(negedge clk);
        mem_i = {da, mk_hdr(RD, aa, 3'd6, 16'h0001)}; v0 = 1'b1; rdy0 = 1'b1;
        @(negedge clk);
        mem_i = {db, mk_hdr(RD, ab, 3'd6, 16'h0002)};
        #1;
        for (int j = 0; j < 16; j++) begin
            i  = j % 8;
            eh = (j < 8) ? mk_hdr(RD, wrap_addr(aa, i), 3'd6, 16'h0001)
                         : mk_hdr(RD, wrap_addr(ab, i), 3'd6, 16'h0002);
            ed = (j < 8) ? slice(da, i) : slice(db, i);
            checks++; if (vo0 !== 1'b1) begin errors++; $display("FAIL b2b_v beat %0d got %b exp 1", j, vo0); end
            checks++; if (hdr0 !== eh) begin errors++; $display("FAIL b2b_hdr beat %0d got %h exp %h", j, hdr0, eh); end
            checks++; if (data0 !== ed) begin errors++; $display("FAIL b2b_data beat %0d got %h exp %h", j, data0, ed); end
            checks++; if (ready0 !== (i == 7)) begin errors++; $display("FAIL b2b_ready beat %0d got %b exp %b", j, ready0, (i == 7)); end
            checks++; if (lock0 !== (i != 7)) begin errors++; $display("FAIL b2b_lock beat %0d got %b exp %b", j, lock0, (i != 7)); end
            @(negedge clk);
            if (j == 7) v0 = 1'b0;
            #1;
        end
        checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL b2b_end_v got %b exp 0", vo0); end
    endtask

    task automatic test_reset_mid();
        logic [IN_W-1:0] d = mk_data(8'h33);
        logic [PA-1:0]   a = 40'h00_8000_0010;
        @(negedge clk);
        mem_i = {d, mk_hdr(RD, a, 3'd6, 16'h0042)}; v0 = 1'b1; rdy0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (data0 !== slice(d, 4)) begin errors++; $display("FAIL rm_pre_data got %h exp %h", data0, slice(d, 4)); end
        checks++; if (lock0 !== 1'b1) begin errors++; $display("FAIL rm_pre_lock got %b exp 1", lock0); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL rm_v got %b exp 0", vo0); end
        checks++; if (lock0 !== 1'b0) begin errors++; $display("FAIL rm_lock got %b exp 0", lock0); end
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL rm_ready got %b exp 0", ready0); end
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL rm_residual_v cyc %0d got %b exp 0", c, vo0); end
            checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL rm_ready_after cyc %0d got %b exp 1", c, ready0); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wide_read();
        test_small_read();
        test_write_ack();
        test_write_cmd();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
